// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: control, butterfly-issue, write-back and status bundle of the FFT stage sequencer
interface fft_stage_sequencer_if #(
  parameter int FFT_SIZE = 16,
  parameter int N_POINTS = 8
);
  localparam int LOG2N = $clog2(N_POINTS);
  localparam int TW_W = $clog2(FFT_SIZE);
  localparam int ST_W = $clog2(LOG2N + 1);
  logic start;
  logic bf_ready;
  logic bf_valid;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [TW_W-1:0] tw_addr;
  logic wb_en;
  logic [LOG2N-1:0] wb_addr_a;
  logic [LOG2N-1:0] wb_addr_b;
  logic [ST_W-1:0] stage;
  logic busy;
  logic done;
  modport master (
    input start, bf_ready,
    output bf_valid, rd_addr_a, rd_addr_b, tw_addr, wb_en, wb_addr_a, wb_addr_b, stage, busy, done
  );
  modport slave (
    output start, bf_ready,
    input bf_valid, rd_addr_a, rd_addr_b, tw_addr, wb_en, wb_addr_a, wb_addr_b, stage, busy, done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: in-place radix-2 DIT FFT stage/butterfly sequencer with hazard-gapped stages and delayed write-back
module fft_stage_sequencer #(
  parameter int FFT_SIZE = 16,
  parameter int N_POINTS = 8,
  parameter int BF_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  fft_stage_sequencer_if.master bus
);
  localparam int LOG2N = $clog2(N_POINTS);
  localparam int TW_W = $clog2(FFT_SIZE);
  localparam int ST_W = $clog2(LOG2N + 1);
  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [ST_W-1:0] stg, stg_nx;
  logic [LOG2N-1:0] b, b_nx, span, j, a;
  logic [2:0] wcnt, wcnt_nx;
  logic [31:0] tw;
  logic valid, issue, last_b, last_s, wait_end;
  logic pv [BF_LATENCY];
  logic [LOG2N-1:0] pa [BF_LATENCY];
  logic [LOG2N-1:0] pb [BF_LATENCY];
  assign span = LOG2N'(1) << stg;
  assign j = b & (span - LOG2N'(1));
  assign a = ((b >> stg) << (stg + ST_W'(1))) | j;
  assign tw = 32'(j) * (32'(N_POINTS) >> (stg + ST_W'(1)));
  assign valid = state == RUN;
  assign issue = valid && bus.bf_ready;
  assign last_b = b == LOG2N'(N_POINTS / 2 - 1);
  assign last_s = stg == ST_W'(LOG2N - 1);
  assign wait_end = wcnt == 3'(BF_LATENCY - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stg <= '0;
      b <= '0;
      wcnt <= '0;
    end else begin
      state <= state_nx;
      stg <= stg_nx;
      b <= b_nx;
      wcnt <= wcnt_nx;
    end
  end
  // WAIT lasts BF_LATENCY cycles so the last write-back of a stage lands before the next stage reads
  always_comb begin
    state_nx = state;
    stg_nx = stg;
    b_nx = b;
    wcnt_nx = wcnt;
    case (state)
      IDLE: state_nx = bus.start ? RUN : IDLE;
      RUN: if (issue) begin
        b_nx = last_b ? '0 : b + LOG2N'(1);
        wcnt_nx = '0;
        state_nx = last_b ? WAIT : RUN;
      end
      WAIT: begin
        wcnt_nx = wcnt + 3'd1;
        state_nx = wait_end ? (last_s ? DONE : RUN) : WAIT;
        stg_nx = (wait_end && !last_s) ? stg + ST_W'(1) : stg;
      end
      default: begin
        state_nx = IDLE;
        stg_nx = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= issue;
      pa[0] <= issue ? a : '0;
      pb[0] <= issue ? a + span : '0;
      for (int i = 1; i < BF_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end
  assign bus.bf_valid = valid;
  assign bus.rd_addr_a = valid ? a : '0;
  assign bus.rd_addr_b = valid ? a + span : '0;
  assign bus.tw_addr = valid ? TW_W'(tw) : '0;
  assign bus.wb_en = pv[BF_LATENCY-1];
  assign bus.wb_addr_a = pa[BF_LATENCY-1];
  assign bus.wb_addr_b = pb[BF_LATENCY-1];
  assign bus.stage = stg;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench for an 8-point/latency-2 and a 16-point/latency-1 sequencer
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0;
  int bad = 0;
  typedef struct {int a; int b; int tw; int st;} iss_t;
  typedef struct {int t; int a; int b;} wb_t;
  iss_t qa[$], qb[$];
  wb_t wa[$], wq[$];
  int da[$], db[$];
  int dcnt_a = 0, dcnt_b = 0;
  iss_t ea, eb;
  wb_t wxa, wxb;
  int tda, tdb;
  fft_stage_sequencer_if #(.FFT_SIZE(16), .N_POINTS(8)) ia ();
  fft_stage_sequencer_if #(.FFT_SIZE(16), .N_POINTS(16)) ib ();
  fft_stage_sequencer #(.FFT_SIZE(16), .N_POINTS(8), .BF_LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fft_stage_sequencer #(.FFT_SIZE(16), .N_POINTS(16), .BF_LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // monitor for the 8-point instance: every valid cycle must show the head of the expected queue
  always @(negedge clk) if (!rst) begin
    if (ia.bf_valid) begin
      chk("issue_a_expected", int'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        ea = qa[0];
        chk("rd_addr_a_a", int'(ia.rd_addr_a), ea.a);
        chk("rd_addr_b_a", int'(ia.rd_addr_b), ea.b);
        chk("tw_addr_a", int'(ia.tw_addr), ea.tw);
        chk("stage_a", int'(ia.stage), ea.st);
        if (ia.bf_ready) begin
          ea = qa.pop_front();
          wxa.t = cyc + 2;
          wxa.a = ea.a;
          wxa.b = ea.b;
          wa.push_back(wxa);
        end
      end
    end
    if (ia.wb_en) begin
      chk("wb_a_expected", int'(wa.size() != 0), 1);
      if (wa.size() != 0) begin
        wxa = wa.pop_front();
        chk("wb_a_cycle", cyc, wxa.t);
        chk("wb_addr_a_a", int'(ia.wb_addr_a), wxa.a);
        chk("wb_addr_b_a", int'(ia.wb_addr_b), wxa.b);
      end
    end
    if (ia.done) begin
      dcnt_a++;
      chk("done_a_expected", int'(da.size() != 0), 1);
      if (da.size() != 0) begin
        tda = da.pop_front();
        if (tda >= 0) chk("done_a_cycle", cyc, tda);
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    if (ib.bf_valid) begin
      chk("issue_b_expected", int'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        eb = qb[0];
        chk("rd_addr_a_b", int'(ib.rd_addr_a), eb.a);
        chk("rd_addr_b_b", int'(ib.rd_addr_b), eb.b);
        chk("tw_addr_b", int'(ib.tw_addr), eb.tw);
        chk("stage_b", int'(ib.stage), eb.st);
        if (ib.bf_ready) begin
          eb = qb.pop_front();
          wxb.t = cyc + 1;
          wxb.a = eb.a;
          wxb.b = eb.b;
          wq.push_back(wxb);
        end
      end
    end
    if (ib.wb_en) begin
      chk("wb_b_expected", int'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        wxb = wq.pop_front();
        chk("wb_b_cycle", cyc, wxb.t);
        chk("wb_addr_a_b", int'(ib.wb_addr_a), wxb.a);
        chk("wb_addr_b_b", int'(ib.wb_addr_b), wxb.b);
      end
    end
    if (ib.done) begin
      dcnt_b++;
      chk("done_b_expected", int'(db.size() != 0), 1);
      if (db.size() != 0) begin
        tdb = db.pop_front();
        if (tdb >= 0) chk("done_b_cycle", cyc, tdb);
      end
    end
  end
  task automatic push_a();
    int ta[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    iss_t e;
    for (int i = 0; i < 12; i++) begin
      e.a = ta[i];
      e.b = tb[i];
      e.tw = tt[i];
      e.st = i / 4;
      qa.push_back(e);
    end
  endtask
  function automatic bit in_run(input int k);
    return (k >= 1 && k <= 4) || (k >= 7 && k <= 10) || (k >= 13 && k <= 16);
  endfunction
  task automatic t1(input bit pulses);
    int d0 = dcnt_a;
    push_a();
    da.push_back(cyc + 19);
    ia.bf_ready = 1'b1;
    ia.start = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      chk("t1_busy", int'(ia.busy), int'(k >= 1 && k <= 19));
      chk("t1_bf_valid", int'(ia.bf_valid), int'(in_run(k)));
      chk("t1_done", int'(ia.done), int'(k == 19));
      @(posedge clk);
      #1;
      ia.start = pulses && (k + 1 == 2 || k + 1 == 19);
    end
    chk("t1_done_count", dcnt_a - d0, 1);
    chk("t1_issues_left", qa.size(), 0);
    chk("t1_wb_left", wa.size(), 0);
  endtask
  task automatic t3();
    int d0 = dcnt_a;
    push_a();
    da.push_back(-1);
    ia.start = 1'b1;
    ia.bf_ready = 1'b1;
    for (int k = 1; k < 300 && dcnt_a == d0; k++) begin
      @(posedge clk);
      #1;
      ia.start = 1'b0;
      ia.bf_ready = ((k - 1) % 3 == 0);
    end
    repeat (3) @(posedge clk);
    #1;
    ia.bf_ready = 1'b1;
    chk("t3_done_count", dcnt_a - d0, 1);
    chk("t3_issues_left", qa.size(), 0);
    chk("t3_wb_left", wa.size(), 0);
  endtask
  task automatic t5();
    push_a();
    ia.bf_ready = 1'b1;
    ia.start = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      ia.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    wa.delete();
    qb.delete();
    wq.delete();
    @(negedge clk);
    chk("t5_busy", int'(ia.busy), 0);
    chk("t5_wb_en", int'(ia.wb_en), 0);
    chk("t5_bf_valid", int'(ia.bf_valid), 0);
    chk("t5_stage", int'(ia.stage), 0);
    @(posedge clk);
    #1;
    t1(1'b0);
  endtask
  task automatic t6();
    int d0 = dcnt_b;
    iss_t e;
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < 8 >> s; g++)
        for (int jj = 0; jj < (1 << s); jj++) begin
          e.a = g * 2 * (1 << s) + jj;
          e.b = e.a + (1 << s);
          e.tw = jj * (16 >> (s + 1));
          e.st = s;
          qb.push_back(e);
        end
    chk("t6_issue_count", qb.size(), 32);
    db.push_back(cyc + 37);
    ib.bf_ready = 1'b1;
    ib.start = 1'b1;
    for (int k = 1; k < 100 && dcnt_b == d0; k++) begin
      @(posedge clk);
      #1;
      ib.start = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t6_done_count", dcnt_b - d0, 1);
    chk("t6_issues_left", qb.size(), 0);
    chk("t6_wb_left", wq.size(), 0);
  endtask
  initial begin
    ia.start = 1'b0;
    ia.bf_ready = 1'b0;
    ib.start = 1'b0;
    ib.bf_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_a", int'(ia.busy), 0);
    chk("rst_valid_a", int'(ia.bf_valid), 0);
    chk("rst_wb_en_a", int'(ia.wb_en), 0);
    chk("rst_done_a", int'(ia.done), 0);
    chk("rst_rd_b_a", int'(ia.rd_addr_b), 0);
    chk("rst_stage_a", int'(ia.stage), 0);
    chk("rst_busy_b", int'(ib.busy), 0);
    chk("rst_wb_en_b", int'(ib.wb_en), 0);
    @(posedge clk);
    #1;
    t1(1'b0);
    t1(1'b1);
    t3();
    t5();
    t6();
    chk("final_done_queue_a", da.size(), 0);
    chk("final_done_queue_b", db.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
